// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch, decode, execute, memory and writeback
// over one shared ALU and one memory port with a timed req/ready handshake.
module multicycle_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] Instruction,
   input  logic        Mem_ready,
   input  logic        Zero,
   output logic        Mem_req,
   output logic        Mem_write,
   output logic        Ir_write,
   output logic        Pc_write,
   output logic [1:0]  Pc_src,
   output logic        Reg_write,
   output logic        Reg_dst,
   output logic        Mem_to_reg,
   output logic        Jal,
   output logic [1:0]  ALUOp,
   output logic        ALUSrc,
   output logic        I_format,
   output logic        Sftmd,
   output logic        Jr,
   output logic        Illegal,
   output logic        Bus_error,
   output logic [2:0]  State
);

   typedef enum logic [2:0] {
      S_BOOT = 3'd0,
      S_IF   = 3'd1,
      S_ID   = 3'd2,
      S_EX   = 3'd3,
      S_MEM  = 3'd4,
      S_WB   = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

   state_t           r_state;
   logic [CNT_W-1:0] r_waitCnt;
   logic             r_abortGap;

   logic [5:0] w_opcode;
   logic [5:0] w_funct;
   logic       w_isR;
   logic       w_isJr;
   logic       w_isI;
   logic       w_isLw;
   logic       w_isSw;
   logic       w_isBeq;
   logic       w_isBne;
   logic       w_isJ;
   logic       w_isJal;
   logic       w_legal;
   logic       w_waitState;
   logic       w_memDone;
   logic       w_timeout;
   logic       w_decodeActive;
   logic       w_unusedInstr;

   assign w_opcode      = Instruction[31:26];
   assign w_funct       = Instruction[5:0];
   assign w_unusedInstr = ^Instruction[25:6];

   assign w_isR   = (w_opcode == 6'b000000);
   assign w_isJr  = w_isR && (w_funct == 6'b001000);
   assign w_isI   = (w_opcode[5:3] == 3'b001);
   assign w_isLw  = (w_opcode == 6'b100011);
   assign w_isSw  = (w_opcode == 6'b101011);
   assign w_isBeq = (w_opcode == 6'b000100);
   assign w_isBne = (w_opcode == 6'b000101);
   assign w_isJ   = (w_opcode == 6'b000010);
   assign w_isJal = (w_opcode == 6'b000011);
   assign w_legal = w_isR | w_isI | w_isLw | w_isSw | w_isBeq | w_isBne | w_isJ | w_isJal;

   // The cycle after a bus abort is a quiet S_IF: no request, ready ignored.
   assign w_waitState = ((r_state == S_IF) && !r_abortGap) || (r_state == S_MEM);
   assign w_memDone   = w_waitState && Mem_ready;
   assign w_timeout   = (TIMEOUT != 0) && w_waitState && !Mem_ready && (r_waitCnt == LP_LAST);

   assign w_decodeActive = (r_state == S_ID) || (r_state == S_EX) ||
                           (r_state == S_MEM) || (r_state == S_WB);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_BOOT;
         r_waitCnt  <= '0;
         r_abortGap <= 1'b0;
      end else begin
         r_abortGap <= 1'b0;
         r_waitCnt  <= '0;
         case (r_state)
            S_BOOT: r_state <= S_IF;
            S_IF: begin
               if (r_abortGap) begin
                  r_state <= S_IF;
               end else if (Mem_ready) begin
                  r_state <= S_ID;
               end else if (w_timeout) begin
                  r_state    <= S_IF;
                  r_abortGap <= 1'b1;
               end else begin
                  r_waitCnt <= r_waitCnt + 1'b1;
               end
            end
            S_ID: r_state <= w_legal ? S_EX : S_IF;
            S_EX: begin
               if (w_isLw || w_isSw)
                  r_state <= S_MEM;
               else if ((w_isR && !w_isJr) || w_isI)
                  r_state <= S_WB;
               else
                  r_state <= S_IF;
            end
            S_MEM: begin
               if (Mem_ready) begin
                  r_state <= w_isLw ? S_WB : S_IF;
               end else if (w_timeout) begin
                  r_state    <= S_IF;
                  r_abortGap <= 1'b1;
               end else begin
                  r_waitCnt <= r_waitCnt + 1'b1;
               end
            end
            S_WB:    r_state <= S_IF;
            default: r_state <= S_BOOT;
         endcase
      end
   end

   // Outputs decode the registered state so they drop as soon as reset asserts.
   always_comb begin
      Mem_req    = 1'b0;
      Mem_write  = 1'b0;
      Ir_write   = 1'b0;
      Pc_write   = 1'b0;
      Pc_src     = 2'b00;
      Reg_write  = 1'b0;
      Jal        = 1'b0;
      Illegal    = 1'b0;
      Bus_error  = 1'b0;
      ALUOp      = 2'b00;
      ALUSrc     = 1'b0;
      I_format   = 1'b0;
      Sftmd      = 1'b0;
      Jr         = 1'b0;
      Reg_dst    = 1'b0;
      Mem_to_reg = 1'b0;
      State      = r_state;

      if (w_decodeActive) begin
         if (w_isLw || w_isSw)
            ALUOp = 2'b00;
         else if (w_isBeq || w_isBne)
            ALUOp = 2'b01;
         else if (w_isR || w_isI)
            ALUOp = 2'b10;
         ALUSrc     = w_isLw | w_isSw | w_isI;
         I_format   = w_isI;
         Sftmd      = w_isR && (w_funct[5:3] == 3'b000);
         Jr         = w_isJr;
         Reg_dst    = w_isR;
         Mem_to_reg = w_isLw;
      end

      case (r_state)
         S_IF: begin
            Mem_req   = !r_abortGap;
            Ir_write  = w_memDone;
            Pc_write  = w_memDone;
            Bus_error = w_timeout;
         end
         S_ID: Illegal = !w_legal;
         S_EX: begin
            if (w_isBeq) begin
               Pc_write = Zero;
               Pc_src   = 2'b01;
            end else if (w_isBne) begin
               Pc_write = !Zero;
               Pc_src   = 2'b01;
            end else if (w_isJ || w_isJal) begin
               Pc_write  = 1'b1;
               Pc_src    = 2'b10;
               Reg_write = w_isJal;
               Jal       = w_isJal;
            end else if (w_isJr) begin
               Pc_write = 1'b1;
               Pc_src   = 2'b11;
            end
         end
         S_MEM: begin
            Mem_req   = 1'b1;
            Mem_write = w_isSw;
            Bus_error = w_timeout;
         end
         S_WB:    Reg_write = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed and random instructions checked cycle by
// cycle against a transaction-level model of the instruction lifecycle.
module tb_multicycle_ctrl;

   localparam int TIMEOUT = 15;

   logic        clock;
   logic        reset;
   logic [31:0] Instruction;
   logic        Mem_ready;
   logic        Zero;
   logic        Mem_req, Mem_write, Ir_write, Pc_write, Reg_write, Reg_dst;
   logic        Mem_to_reg, Jal, ALUSrc, I_format, Sftmd, Jr, Illegal, Bus_error;
   logic [1:0]  Pc_src, ALUOp;
   logic [2:0]  State;

   int assertCount = 0;
   int failCount   = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic        zero;
      logic        ready;
      logic [2:0]  state;
      logic [9:0]  strb;
      logic [7:0]  dexp;
      logic [7:0]  dmask;
   } cyc_t;

   cyc_t        expQ[$];
   logic [31:0] curInstr;
   logic        curZero;
   logic [7:0]  curDexp;
   logic [7:0]  curMask;
   logic [5:0]  functs  [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
   logic [5:0]  badOps  [4] = '{6'h3F, 6'h01, 6'h10, 6'h20};

   multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
      .clock(clock), .reset(reset), .Instruction(Instruction), .Mem_ready(Mem_ready),
      .Zero(Zero), .Mem_req(Mem_req), .Mem_write(Mem_write), .Ir_write(Ir_write),
      .Pc_write(Pc_write), .Pc_src(Pc_src), .Reg_write(Reg_write), .Reg_dst(Reg_dst),
      .Mem_to_reg(Mem_to_reg), .Jal(Jal), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
      .I_format(I_format), .Sftmd(Sftmd), .Jr(Jr), .Illegal(Illegal),
      .Bus_error(Bus_error), .State(State)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Every comparison funnels through here so the counts stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [9:0] strb(input logic memReq, input logic memWrite, input logic irW,
                                       input logic pcW, input logic [1:0] pcSrc, input logic regW,
                                       input logic jal, input logic ill, input logic bus);
      return {memReq, memWrite, irW, pcW, pcSrc, regW, jal, ill, bus};
   endfunction

   function automatic logic [9:0] obsStrb();
      return {Mem_req, Mem_write, Ir_write, Pc_write, Pc_src, Reg_write, Jal, Illegal, Bus_error};
   endfunction

   function automatic logic [7:0] obsDecode();
      return {ALUOp, ALUSrc, I_format, Sftmd, Jr, Reg_dst, Mem_to_reg};
   endfunction

   task automatic pushCycle(input logic ready, input logic [2:0] st, input logic [9:0] s);
      cyc_t c;
      c.instr = curInstr;
      c.zero  = curZero;
      c.ready = ready;
      c.state = st;
      c.strb  = s;
      c.dexp  = (st >= 3'd2) ? curDexp : 8'h00;
      c.dmask = (st >= 3'd2) ? curMask : 8'hFF;
      expQ.push_back(c);
   endtask

   // A memory wait phase: waitN idle cycles then ready, or abort after TIMEOUT cycles.
   task automatic pushWait(input logic [2:0] st, input int waitN, input logic isStore, output logic timedOut);
      logic ready, bus, fetch;
      timedOut = 1'b0;
      for (int k = 0; k <= waitN && k < TIMEOUT; k++) begin
         ready = (k == waitN);
         bus   = !ready && (k == TIMEOUT - 1);
         fetch = ready && (st == 3'd1);
         pushCycle(ready, st, strb(1'b1, isStore, fetch, fetch, 2'b00, 1'b0, 1'b0, 1'b0, bus));
         if (bus) timedOut = 1'b1;
      end
   endtask

   task automatic pushGap();
      pushCycle(1'($urandom), 3'd1, 10'd0);
   endtask

   task automatic buildTxn(input logic [31:0] instr, input logic zero, input int ifWait, input int memWait);
      logic [5:0] op, fn;
      logic isR, isJr, isI, isLw, isSw, isBeq, isBne, isJ, isJal, legal, to;
      logic [1:0] aluOp;
      op = instr[31:26];
      fn = instr[5:0];
      isR   = (op == 6'd0);
      isJr  = isR && (fn == 6'b001000);
      isI   = (op[5:3] == 3'b001);
      isLw  = (op == 6'b100011);
      isSw  = (op == 6'b101011);
      isBeq = (op == 6'b000100);
      isBne = (op == 6'b000101);
      isJ   = (op == 6'b000010);
      isJal = (op == 6'b000011);
      legal = isR | isI | isLw | isSw | isBeq | isBne | isJ | isJal;
      aluOp = (isLw | isSw) ? 2'b00 : (isBeq | isBne) ? 2'b01 : (isR | isI) ? 2'b10 : 2'b00;
      curInstr = instr;
      curZero  = zero;
      curDexp  = {aluOp, isLw | isSw | isI, isI, isR && (fn[5:3] == 3'b000), isJr, isR, isLw};
      curMask  = (isJ | isJal | !legal) ? 8'h3D : 8'hFF;

      pushWait(3'd1, ifWait, 1'b0, to);
      if (to) begin
         pushGap();
         pushWait(3'd1, 0, 1'b0, to);
      end
      if (!legal) begin
         pushCycle(1'($urandom), 3'd2, strb(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
         return;
      end
      pushCycle(1'($urandom), 3'd2, 10'd0);
      if (isBeq)
         pushCycle(1'($urandom), 3'd3, strb(1'b0, 1'b0, 1'b0, zero, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
      else if (isBne)
         pushCycle(1'($urandom), 3'd3, strb(1'b0, 1'b0, 1'b0, !zero, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
      else if (isJ || isJal)
         pushCycle(1'($urandom), 3'd3, strb(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, isJal, isJal, 1'b0, 1'b0));
      else if (isJr)
         pushCycle(1'($urandom), 3'd3, strb(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0));
      else
         pushCycle(1'($urandom), 3'd3, 10'd0);

      if (isLw || isSw) begin
         pushWait(3'd4, memWait, isSw, to);
         if (to) begin
            pushGap();
            return;
         end
         if (isLw)
            pushCycle(1'($urandom), 3'd5, strb(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
      end else if ((isR && !isJr) || isI) begin
         pushCycle(1'($urandom), 3'd5, strb(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
      end
   endtask

   // Plays queued cycles: drive just after the rising edge, check on the falling edge.
   task automatic applyStimulus(input int limit);
      cyc_t c;
      int n = 0;
      while (expQ.size() > 0 && n < limit) begin
         c = expQ.pop_front();
         n++;
         #1;
         Instruction = c.instr;
         Zero        = c.zero;
         Mem_ready   = c.ready;
         @(negedge clock);
         checkOutput($sformatf("state[%08h]", c.instr), 32'(State), 32'(c.state));
         checkOutput($sformatf("strobes[%08h] st%0d", c.instr, c.state), 32'(obsStrb()), 32'(c.strb));
         checkOutput($sformatf("decode[%08h] st%0d", c.instr, c.state),
                     32'(obsDecode() & c.dmask), 32'(c.dexp & c.dmask));
         @(posedge clock);
      end
   endtask

   function automatic logic [31:0] randInstr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 9))
         0: return {6'd0, r[25:6], functs[$urandom_range(0, 6)]};
         1: return {6'd0, r[25:21], 15'd0, 6'b001000};
         2: return {3'b001, r[28:0]};
         3: return {6'b100011, r[25:0]};
         4: return {6'b101011, r[25:0]};
         5: return {6'b000100, r[25:0]};
         6: return {6'b000101, r[25:0]};
         7: return {6'b000010, r[25:0]};
         8: return {6'b000011, r[25:0]};
         default: return {badOps[$urandom_range(0, 3)], r[25:0]};
      endcase
   endfunction

   function automatic int randWait();
      return ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 17)) : int'($urandom_range(0, 3));
   endfunction

   initial begin
      reset       = 1'b0;
      Instruction = 32'h8D090004;
      Mem_ready   = 1'b1;
      Zero        = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("reset state", 32'(State), 32'd0);
      checkOutput("reset strobes", 32'(obsStrb()), 32'd0);
      checkOutput("reset decode", 32'(obsDecode()), 32'd0);
      reset = 1'b1;
      #1;
      checkOutput("boot state", 32'(State), 32'd0);
      @(posedge clock);

      buildTxn(32'h01095020, 1'b0, 0, 0);
      buildTxn(32'h8D090004, 1'b0, 0, 3);
      buildTxn(32'hAD090004, 1'b0, 1, 0);
      buildTxn(32'h11090003, 1'b1, 0, 0);
      buildTxn(32'h11090003, 1'b0, 0, 0);
      buildTxn(32'h01000008, 1'b0, 0, 0);
      buildTxn(32'h00094080, 1'b0, 0, 0);
      buildTxn(32'h0C000010, 1'b0, 0, 0);
      buildTxn(32'h01095020, 1'b0, 15, 0);
      buildTxn(32'hFC000000, 1'b0, 0, 0);
      buildTxn(32'h8D090004, 1'b0, 0, 15);
      applyStimulus(10000);

      for (int t = 0; t < 60; t++) begin
         buildTxn(randInstr(), 1'($urandom), randWait(), randWait());
         applyStimulus(10000);
      end

      $display("[TB] reset during a store in S_MEM");
      buildTxn(32'hAD090004, 1'b0, 0, 20);
      applyStimulus(5);
      expQ.delete();
      #1;
      Mem_ready = 1'b0;
      #1;
      checkOutput("pre-reset Mem_req", 32'(Mem_req), 32'd1);
      checkOutput("pre-reset Mem_write", 32'(Mem_write), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("async Mem_req", 32'(Mem_req), 32'd0);
      checkOutput("async Mem_write", 32'(Mem_write), 32'd0);
      checkOutput("async state", 32'(State), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      checkOutput("post-reset boot", 32'(State), 32'd0);
      checkOutput("post-reset strobes", 32'(obsStrb()), 32'd0);
      @(posedge clock);
      #1;
      checkOutput("post-reset fetch state", 32'(State), 32'd1);
      checkOutput("post-reset fetch req", 32'(Mem_req), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control FSM that sequences one shared ALU and one shared instruction/data memory port per instruction through fetch, decode, execute, memory and writeback.
It latches nothing itself. It decodes the instruction word presented at Instruction and drives the ALU control inputs (ALUOp, ALUSrc, I_format, Sftmd, Jr).
It also drives the datapath write strobes and runs a req/ready handshake with memory.
It sits between the instruction register, ALU, register file and memory interface.

Parameters:
TIMEOUT, 15, max cycles waiting for Mem_ready in S_IF/S_MEM before abort; 0 disables timeout
CNT_W, 4, width of wait counter; must hold TIMEOUT

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
Instruction  in  32  current IR contents; opcode [31:26], funct [5:0]
Mem_ready  in  1  memory completes request this cycle
Zero  in  1  ALU zero flag
Mem_req  out  1  memory request (fetch or data)
Mem_write  out  1  data store; valid only with Mem_req
Ir_write  out  1  load IR from memory read data
Pc_write  out  1  update PC (PC+4, branch, jump or jr target)
Pc_src  out  2  00 PC+4, 01 branch Addr_Result, 10 jump target, 11 register (jr)
Reg_write  out  1  register file write strobe
Reg_dst  out  1  1 = rd, 0 = rt
Mem_to_reg  out  1  writeback source is memory
Jal  out  1  write PC+4 to $31
ALUOp  out  2  00 add (lw/sw), 01 subtract (beq/bne), 10 R-type/I-format
ALUSrc  out  1  second ALU operand is the immediate
I_format  out  1  opcode[31:29]==3'b001
Sftmd  out  1  R-type and funct[5:3]==3'b000
Jr  out  1  R-type and funct==6'b001000
Illegal  out  1  one-cycle pulse: undecodable opcode
Bus_error  out  1  one-cycle pulse: memory timeout
State  out  3  current state encoding, for debug

Behaviour:
- States: S_BOOT=0, S_IF=1, S_ID=2, S_EX=3, S_MEM=4, S_WB=5.
- reset low: state goes to S_BOOT immediately; wait counter = 0; every output is 0 and State=0.
- S_BOOT: all outputs 0; goes to S_IF on the next edge.
- S_IF:
  - Mem_req=1 and Mem_write=0.
  - When Mem_ready=1: Ir_write=1 and Pc_write=1 with Pc_src=00 in the same cycle, then go to S_ID.
  - Otherwise stay in S_IF and increment the counter.
- S_ID:
  - One cycle, then go to S_EX.
  - Legal opcodes: 000000, 000010, 000011, 000100, 000101, 100011, 101011, 001xxx.
  - Any other opcode: Illegal=1 this cycle, next state S_IF, no writes.
- Decode outputs (ALUOp, ALUSrc, I_format, Sftmd, Jr, Reg_dst, Mem_to_reg) are combinational from Instruction in S_ID, S_EX, S_MEM and S_WB. They are 0 in S_BOOT and S_IF.
- ALUSrc=1 for lw, sw and I-format.
- S_EX:
  - lw/sw: next state S_MEM.
  - beq/bne: Pc_write = Zero (beq) or !Zero (bne), with Pc_src=01; next state S_IF.
  - j: Pc_write=1, Pc_src=10; next state S_IF.
  - jal: as j, plus Reg_write=1 and Jal=1; next state S_IF.
  - jr: Pc_write=1, Pc_src=11; next state S_IF.
  - Other R-type and I-format: next state S_WB.
- S_MEM:
  - Mem_req=1; Mem_write=1 for sw.
  - On Mem_ready: lw goes to S_WB, sw goes to S_IF.
  - Otherwise hold state and increment the counter.
- S_WB: Reg_write=1 for exactly one cycle; Mem_to_reg=1 for lw; next state S_IF.
- Wait counter:
  - Cleared on every state change.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without Mem_ready: Bus_error=1 this cycle, Mem_req drops next cycle, next state S_IF.
  - No Ir_write, Pc_write or Reg_write occurs on the aborted cycle.
  - Mem_ready on that same cycle wins over the timeout; no Bus_error.
- Mem_ready is ignored outside S_IF and S_MEM.
- Strobes are single-cycle. Reg_write, Ir_write and Pc_write are never asserted in S_BOOT.
- Latency with Mem_ready always 1, from entering S_IF:
  - R-type/I-format: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne/j/jal/jr: 3 cycles.
- Reset mid-operation: immediate return to S_BOOT; any in-flight Mem_req and strobes drop asynchronously.

Test Plan:
- Release reset, Mem_ready tied 1, Instruction=0x01095020 (add $10,$8,$9). Expect State sequence 0,1,2,3,5,1. ALUOp=10, ALUSrc=0, Reg_dst=1. Reg_write high only in S_WB.
- Instruction=0x8D090004 (lw), Mem_ready held 0 for 3 cycles in S_MEM then 1. Expect Mem_req=1 and Mem_write=0 for 4 cycles, then S_WB with Mem_to_reg=1 and Reg_write=1. ALUOp=00, ALUSrc=1.
- Instruction=0x11090003 (beq): with Zero=1, expect Pc_write=1, Pc_src=01 in S_EX. Repeat with Zero=0: expect Pc_write=0. Both return to S_IF after 3 cycles.
- Instruction=0x00000008|(8<<21) (jr $8): expect Jr=1 and Pc_src=11 in S_EX. Instruction=0x00094080 (sll): expect Sftmd=1 and Jr=0.
- TIMEOUT=15, Mem_ready held 0 in S_IF. Expect Bus_error pulse on the 15th cycle, then a fresh S_IF with no Ir_write. Repeat with Instruction opcode 0x3F: expect an Illegal pulse in S_ID, then S_IF.
- Assert reset low while in S_MEM with Mem_write=1. Expect Mem_req=0 and Mem_write=0 immediately. After release: S_BOOT, then S_IF.
